// File: rtl/dc_exc_ctrl_pkg.sv
// dc_exc_ctrl_pkg: shared definitions for the D-cache exception controller.
//   exc_state_e : controller state encoding (2 bits)
//   VEC_GP      : vector for protection (segment-limit / RW) faults
//   VEC_PF      : vector for page faults
package dc_exc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DRAIN  = 2'b01,
    REQ    = 2'b10,
    IN_ISR = 2'b11
  } exc_state_e;

  localparam logic [7:0] VEC_GP = 8'h0D;
  localparam logic [7:0] VEC_PF = 8'h0E;

endpackage

// File: rtl/dc_exc_ctrl_sat_counter.sv
// dc_exc_ctrl_sat_counter: W-bit up counter that sticks at all-ones.
//   clk   : core clock
//   clr_n : synchronous active-low clear
//   inc   : increment enable
//   count : current count
module dc_exc_ctrl_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dc_exc_ctrl.sv
// dc_exc_ctrl: turns D-cache checker fault flags in RO into a precise
// exception: captures class/address/EIP, flushes younger stages, waits for
// older ones to drain, handshakes ISR entry and masks the checker until IRET.
//   Inputs : clk, rst_n (sync, active low), v_ro_valid, ro_stall, ro_eip,
//            dc_exp, dc_prot_exp, dc_page_fault, dc_rd_exp, dc_wr_exp,
//            mem_rd_addr, mem_wr_addr, pipe_older_empty, isr_ack, iret_retire
//   Outputs: isr, exp_flush, fetch_hold, isr_req, isr_vector, fault_addr,
//            fault_eip, exp_count
//
// state  | meaning
// IDLE   | normal execution, faults in RO are captured
// DRAIN  | younger stages flushed, waiting for older instructions to retire
// REQ    | requesting ISR entry, vector and fault info held stable
// IN_ISR | handler running, checker masked until IRET retires
module dc_exc_ctrl #(
  parameter logic [7:0] VEC_GP = dc_exc_ctrl_pkg::VEC_GP,
  parameter logic [7:0] VEC_PF = dc_exc_ctrl_pkg::VEC_PF,
  parameter int         CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_ro_valid,
  input  logic             ro_stall,
  input  logic [31:0]      ro_eip,
  input  logic             dc_exp,
  input  logic             dc_prot_exp,
  input  logic             dc_page_fault,
  input  logic             dc_rd_exp,
  input  logic             dc_wr_exp,
  input  logic [31:0]      mem_rd_addr,
  input  logic [31:0]      mem_wr_addr,
  input  logic             pipe_older_empty,
  input  logic             isr_ack,
  input  logic             iret_retire,
  output logic             isr,
  output logic             exp_flush,
  output logic             fetch_hold,
  output logic             isr_req,
  output logic [7:0]       isr_vector,
  output logic [31:0]      fault_addr,
  output logic [31:0]      fault_eip,
  output logic [CNT_W-1:0] exp_count
);

  import dc_exc_ctrl_pkg::*;

  exc_state_e  state_q, state_d;
  logic        exp_flush_q, exp_flush_d;
  logic [7:0]  isr_vector_q, isr_vector_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] fault_eip_q, fault_eip_d;
  logic        cap;

  // Page fault is the default class (also covers the illegal "no class"
  // case) and the write address is the fallback, so these two flags carry
  // no extra information.
  logic        unused_flags;
  assign unused_flags = dc_page_fault ^ dc_wr_exp;

  always_comb begin
    cap          = (state_q == IDLE) & v_ro_valid & ~ro_stall & dc_exp;
    state_d      = state_q;
    exp_flush_d  = cap;
    isr_vector_d = isr_vector_q;
    fault_addr_d = fault_addr_q;
    fault_eip_d  = fault_eip_q;

    case (state_q)
      IDLE: begin
        if (cap) begin
          state_d      = DRAIN;
          isr_vector_d = dc_prot_exp ? VEC_GP : VEC_PF;
          fault_addr_d = dc_rd_exp ? mem_rd_addr : mem_wr_addr;
          fault_eip_d  = ro_eip;
        end
      end
      DRAIN: begin
        if (pipe_older_empty) state_d = REQ;
      end
      REQ: begin
        if (isr_ack) state_d = IN_ISR;
      end
      IN_ISR: begin
        if (iret_retire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      exp_flush_q  <= 1'b0;
      isr_vector_q <= '0;
      fault_addr_q <= '0;
      fault_eip_q  <= '0;
    end else begin
      state_q      <= state_d;
      exp_flush_q  <= exp_flush_d;
      isr_vector_q <= isr_vector_d;
      fault_addr_q <= fault_addr_d;
      fault_eip_q  <= fault_eip_d;
    end
  end

  dc_exc_ctrl_sat_counter #(
    .W(CNT_W)
  ) u_exp_cnt (
    .clk  (clk),
    .clr_n(rst_n),
    .inc  (cap),
    .count(exp_count)
  );

  // Status outputs decode the state register only, so no input reaches
  // an output combinationally.
  assign fetch_hold = (state_q == DRAIN) || (state_q == REQ);
  assign isr_req    = (state_q == REQ);
  assign isr        = (state_q == IN_ISR);
  assign exp_flush  = exp_flush_q;
  assign isr_vector = isr_vector_q;
  assign fault_addr = fault_addr_q;
  assign fault_eip  = fault_eip_q;

endmodule

// File: doc/dc_exc_ctrl.md
Name: dc_exc_ctrl

Overview:
- Sits directly downstream of the D-cache exception checker in the read-operands (RO) stage.
- Turns its combinational fault flags into a precise exception:
  - captures the fault class, faulting linear address and EIP;
  - flushes younger stages and drains older ones;
  - performs an ISR-entry handshake with the vector logic;
  - drives the `isr` mask back into the checker until IRET retires.

Parameters:
- VEC_GP, 8'h0D, vector for protection (segment-limit / RW) exception
- VEC_PF, 8'h0E, vector for page fault
- CNT_W, 8, width of saturating fault counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- v_ro_valid  in  1  RO stage holds a valid instruction
- ro_stall  in  1  RO stage stalled this cycle
- ro_eip  in  32  EIP of instruction in RO
- dc_exp  in  1  any D-cache exception (from checker)
- dc_prot_exp  in  1  protection exception
- dc_page_fault  in  1  page fault
- dc_rd_exp  in  1  exception on read path
- dc_wr_exp  in  1  exception on write path
- mem_rd_addr  in  32  read linear address
- mem_wr_addr  in  32  write linear address
- pipe_older_empty  in  1  all instructions older than RO have retired
- isr_ack  in  1  vector logic accepted request
- iret_retire  in  1  IRET retiring in WB
- isr  out  1  in-handler mask fed to checker
- exp_flush  out  1  one-cycle kill of RO and younger stages
- fetch_hold  out  1  front end must not issue
- isr_req  out  1  request ISR entry
- isr_vector  out  8  vector number
- fault_addr  out  32  faulting linear address (CR2-like)
- fault_eip  out  32  EIP to push
- exp_count  out  CNT_W  saturating count of taken exceptions

Behaviour:
- All state updates on posedge clk; rst_n=0 sampled at an edge forces IDLE and all outputs to 0, including fault_addr, fault_eip, isr_vector and exp_count. Reset wins over every other event.
- Capture condition: cap = state==IDLE & v_ro_valid & ~ro_stall & dc_exp.
- Priority on capture:
  - dc_prot_exp beats dc_page_fault: isr_vector = prot ? VEC_GP : VEC_PF.
  - Read path beats write path: fault_addr = dc_rd_exp ? mem_rd_addr : mem_wr_addr.
  - fault_eip = ro_eip.
  - Registers hold until the next capture.
- FSM states IDLE, DRAIN, REQ, IN_ISR:
  - IDLE: on cap, go to DRAIN and pulse exp_flush=1 for exactly the cycle after capture. exp_count increments, saturating at all-ones.
  - DRAIN: fetch_hold=1. When pipe_older_empty=1, go to REQ. If it is already 1 on entry, REQ is reached the next cycle (1 cycle in DRAIN).
  - REQ: fetch_hold=1, isr_req=1. isr_req stays high and isr_vector/fault_* stay stable until isr_ack. On isr_ack go to IN_ISR; isr_req drops the following cycle.
  - IN_ISR: isr=1, fetch_hold=0. On iret_retire go to IDLE; isr=0 from the next cycle.
- Latency: capture edge -> exp_flush high 1 cycle later. Minimum capture -> isr_req is 2 cycles.
- Masking:
  - dc_exp is ignored in DRAIN, REQ and IN_ISR; no re-capture and no count change.
  - On the iret_retire cycle isr is still 1, so a concurrent dc_exp is not captured. A fault in the following cycle is captured normally.
- iret_retire outside IN_ISR and isr_ack outside REQ are ignored.
- dc_exp=1 with neither prot nor page fault set (illegal): treat as page fault.
- Registered outputs only; no combinational path from inputs to outputs.

Decomposition:
- Shared package / defines: state encoding (2 bits: IDLE=00, DRAIN=01, REQ=10, IN_ISR=11), VEC_GP and VEC_PF constants.
- One sub-module: sat_counter (CNT_W-bit enable-increment saturating counter with synchronous active-low clear).
- FSM and capture registers stay in the top module.

Test Plan:
- Page fault read: dc_exp=1, dc_page_fault=1, dc_rd_exp=1, mem_rd_addr=32'h0040_1004, ro_eip=32'h0000_1234, pipe_older_empty=1 -> exp_flush pulse next cycle; isr_req at +2; isr_vector=8'h0E, fault_addr=32'h0040_1004, fault_eip=32'h0000_1234; exp_count=1.
- Prot and page fault together on write: dc_prot_exp=1, dc_page_fault=1, dc_wr_exp=1, mem_wr_addr=32'h0000_FFFE -> isr_vector=8'h0D, fault_addr=32'h0000_FFFE.
- Drain wait: pipe_older_empty=0 for 5 cycles after capture -> fetch_hold=1 and isr_req=0 throughout; isr_req rises the cycle after pipe_older_empty=1; isr_req held 4 cycles until isr_ack.
- Mask: second dc_exp during REQ and on the iret_retire cycle -> no capture, exp_count unchanged. A dc_exp one cycle after IRET -> captured.
- Stall gating: dc_exp=1 with ro_stall=1 -> no capture; capture on the first cycle ro_stall=0.
- Reset mid-REQ: rst_n=0 for one edge while isr_req=1 -> next cycle all outputs 0, state IDLE. Also force exp_count to 255 and fault again -> stays 255.
